aw_write_arbiter: RTL and testbench

Sequencing controller and arbiter for the 2:1 write-address mux in the AXI interconnect. It arbitrates between the S00 and S01 write masters and drives the mux select, Selected_Slave. It holds that grant through the full write transaction (AW handshake, W burst, B response), so the W and B channel muxes follow the same selection. It also checks that the WLAST beat position matches the granted AWLEN.

---
 rtl/axi_ic_pkg.sv | 15 +
 rtl/rr_arb_2.sv | 32 +++
 rtl/aw_write_arbiter.sv | 145 ++++++++++++++
 tb/tb_aw_write_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/axi_ic_pkg.sv
// Shared encodings for the AXI interconnect write/read address sequencers.
// State codes use a 2-bit encoding; any unlisted code recovers to idle.
package axi_ic_pkg;

   typedef logic [1:0] aw_state_t;

   localparam aw_state_t AW_IDLE = 2'b00;
   localparam aw_state_t AW_ADDR = 2'b01;
   localparam aw_state_t AW_DATA = 2'b11;
   localparam aw_state_t AW_RESP = 2'b10;

   localparam logic SEL_S00 = 1'b0;
   localparam logic SEL_S01 = 1'b1;

endpackage

// File: rtl/rr_arb_2.sv
// Two-requester winner selection: round-robin against last_grant, or fixed S00 priority.
// Purely combinational so it can be shared with the read-address sequencer.
module rr_arb_2
   import axi_ic_pkg::*;
#(
   parameter int Fixed_Priority = 0
) (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant,
   output logic       any_req
);

   // Winner decode; on a tie round-robin favours the master not granted last.
   always_comb begin
      grant   = SEL_S00;
      any_req = |req;
      case (req)
         2'b01:   grant = SEL_S00;
         2'b10:   grant = SEL_S01;
         2'b11: begin
            if (Fixed_Priority != 0) begin
               grant = SEL_S00;
            end else begin
               grant = ~last_grant;
            end
         end
         default: grant = SEL_S00;
      endcase
   end

endmodule

// File: rtl/aw_write_arbiter.sv
// Write-path sequencer for the 2:1 AW/W/B mux: grants one master per full write
// transaction and flags WLAST positions that disagree with the granted AWLEN.
module aw_write_arbiter
   import axi_ic_pkg::*;
#(
   parameter int S_Aw_len       = 8,
   parameter int Fixed_Priority = 0
) (
   input  logic                ACLK,
   input  logic                ARESET,
   input  logic                S00_AXI_awvalid,
   input  logic [S_Aw_len-1:0] S00_AXI_awlen,
   input  logic                S01_AXI_awvalid,
   input  logic [S_Aw_len-1:0] S01_AXI_awlen,
   input  logic                M_AXI_awready,
   input  logic                Sel_S_AXI_wvalid,
   input  logic                Sel_S_AXI_wlast,
   input  logic                M_AXI_wready,
   input  logic                M_AXI_bvalid,
   input  logic                Sel_S_AXI_bready,
   output logic                Selected_Slave,
   output logic                S00_AXI_awready,
   output logic                S01_AXI_awready,
   output logic                AW_En,
   output logic                W_En,
   output logic                B_En,
   output logic                Wlast_Err
);

   localparam logic [S_Aw_len-1:0] CNT_ONE = S_Aw_len'(1);
   localparam logic [S_Aw_len-1:0] CNT_MAX = {S_Aw_len{1'b1}};

   aw_state_t           state_r;
   aw_state_t           next_state_s;
   logic                selected_r;
   logic                last_grant_r;
   logic [S_Aw_len-1:0] beat_cnt_r;
   logic [S_Aw_len-1:0] len_q_r;
   logic                wlast_err_r;

   logic                win_s;
   logic                any_req_s;
   logic                sel_awvalid_s;
   logic [S_Aw_len-1:0] sel_awlen_s;
   logic                aw_hs_s;
   logic                w_beat_s;
   logic                b_hs_s;
   logic                len_match_s;

   rr_arb_2 #(
      .Fixed_Priority (Fixed_Priority)
   ) u_rr_arb_2 (
      .req        ({S01_AXI_awvalid, S00_AXI_awvalid}),
      .last_grant (last_grant_r),
      .grant      (win_s),
      .any_req    (any_req_s)
   );

   assign sel_awvalid_s  = (selected_r == SEL_S01) ? S01_AXI_awvalid : S00_AXI_awvalid;
   assign sel_awlen_s    = (selected_r == SEL_S01) ? S01_AXI_awlen : S00_AXI_awlen;
   assign aw_hs_s        = sel_awvalid_s & M_AXI_awready;
   assign w_beat_s       = Sel_S_AXI_wvalid & M_AXI_wready;
   assign b_hs_s         = M_AXI_bvalid & Sel_S_AXI_bready;
   assign len_match_s    = (beat_cnt_r == len_q_r);
   assign Selected_Slave = selected_r;
   assign Wlast_Err      = wlast_err_r;

   // State register.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_r <= AW_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic: one outstanding write, released only by the B handshake.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         AW_IDLE: if (any_req_s) next_state_s = AW_ADDR;
         AW_ADDR: if (aw_hs_s) next_state_s = AW_DATA;
         AW_DATA: if (w_beat_s && Sel_S_AXI_wlast) next_state_s = AW_RESP;
         AW_RESP: if (b_hs_s) next_state_s = AW_IDLE;
         default: next_state_s = AW_IDLE;
      endcase
   end

   // Grant, burst length, beat counter and sticky length-error tracking.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         selected_r   <= SEL_S00;
         last_grant_r <= SEL_S01;
         beat_cnt_r   <= '0;
         len_q_r      <= '0;
         wlast_err_r  <= 1'b0;
      end else begin
         case (state_r)
            AW_IDLE: begin
               if (any_req_s) selected_r <= win_s;
            end
            AW_ADDR: begin
               if (aw_hs_s) begin
                  len_q_r    <= sel_awlen_s;
                  beat_cnt_r <= '0;
               end
            end
            AW_DATA: begin
               if (w_beat_s) begin
                  beat_cnt_r <= (beat_cnt_r == CNT_MAX) ? beat_cnt_r : beat_cnt_r + CNT_ONE;
                  // beat_cnt_r is the zero-based index of this beat; the last must equal awlen.
                  if (Sel_S_AXI_wlast != len_match_s) wlast_err_r <= 1'b1;
               end
            end
            AW_RESP: begin
               if (b_hs_s) last_grant_r <= selected_r;
            end
            default: ;
         endcase
      end
   end

   // Output decode from the registered state.
   always_comb begin
      AW_En           = 1'b0;
      W_En            = 1'b0;
      B_En            = 1'b0;
      S00_AXI_awready = 1'b0;
      S01_AXI_awready = 1'b0;
      case (state_r)
         AW_ADDR: begin
            AW_En = 1'b1;
            if (selected_r == SEL_S01) begin
               S01_AXI_awready = M_AXI_awready;
            end else begin
               S00_AXI_awready = M_AXI_awready;
            end
         end
         AW_DATA: W_En = 1'b1;
         AW_RESP: B_En = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_aw_write_arbiter.sv
// Randomized bench for aw_write_arbiter: a round-robin and a fixed-priority instance,
// each checked every cycle against a transaction-level reference model.
module tb_aw_write_arbiter;

   localparam int NCYC = 4000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       areset;
   logic [1:0] s00_awvalid, s01_awvalid, m_awready, wvalid, wlast, wready, bvalid, bready;
   logic [7:0] s00_awlen [2];
   logic [7:0] s01_awlen [2];
   logic [1:0] sel_slave, s00_awready, s01_awready, aw_en, w_en, b_en, wlast_err;

   aw_write_arbiter #(.S_Aw_len(8), .Fixed_Priority(0)) u_dut_rr (
      .ACLK(clk), .ARESET(areset),
      .S00_AXI_awvalid(s00_awvalid[0]), .S00_AXI_awlen(s00_awlen[0]),
      .S01_AXI_awvalid(s01_awvalid[0]), .S01_AXI_awlen(s01_awlen[0]),
      .M_AXI_awready(m_awready[0]), .Sel_S_AXI_wvalid(wvalid[0]), .Sel_S_AXI_wlast(wlast[0]),
      .M_AXI_wready(wready[0]), .M_AXI_bvalid(bvalid[0]), .Sel_S_AXI_bready(bready[0]),
      .Selected_Slave(sel_slave[0]), .S00_AXI_awready(s00_awready[0]),
      .S01_AXI_awready(s01_awready[0]), .AW_En(aw_en[0]), .W_En(w_en[0]), .B_En(b_en[0]),
      .Wlast_Err(wlast_err[0])
   );

   aw_write_arbiter #(.S_Aw_len(8), .Fixed_Priority(1)) u_dut_fp (
      .ACLK(clk), .ARESET(areset),
      .S00_AXI_awvalid(s00_awvalid[1]), .S00_AXI_awlen(s00_awlen[1]),
      .S01_AXI_awvalid(s01_awvalid[1]), .S01_AXI_awlen(s01_awlen[1]),
      .M_AXI_awready(m_awready[1]), .Sel_S_AXI_wvalid(wvalid[1]), .Sel_S_AXI_wlast(wlast[1]),
      .M_AXI_wready(wready[1]), .M_AXI_bvalid(bvalid[1]), .Sel_S_AXI_bready(bready[1]),
      .Selected_Slave(sel_slave[1]), .S00_AXI_awready(s00_awready[1]),
      .S01_AXI_awready(s01_awready[1]), .AW_En(aw_en[1]), .W_En(w_en[1]), .B_En(b_en[1]),
      .Wlast_Err(wlast_err[1])
   );

   // Reference model: a write is a sequence of milestones (granted, address accepted,
   // last data accepted); the phase is whichever milestone is next.
   bit m_active [2];
   bit m_aw_done[2];
   bit m_w_done [2];
   bit m_sel    [2];
   bit m_prev   [2];
   bit m_err    [2];
   int m_beats  [2];
   int m_blen   [2];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: observed %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   task automatic model_reset(input int k);
      m_active[k]  = 1'b0;
      m_aw_done[k] = 1'b0;
      m_w_done[k]  = 1'b0;
      m_sel[k]     = 1'b0;
      m_prev[k]    = 1'b1;
      m_err[k]     = 1'b0;
      m_beats[k]   = 0;
      m_blen[k]    = 0;
   endtask

   task automatic model_step(input int k);
      bit fixed;
      fixed = (k == 1);
      if (areset) begin
         model_reset(k);
      end else if (!m_active[k]) begin
         if (s00_awvalid[k] || s01_awvalid[k]) begin
            if (s00_awvalid[k] && s01_awvalid[k]) m_sel[k] = fixed ? 1'b0 : !m_prev[k];
            else                                  m_sel[k] = s01_awvalid[k];
            m_active[k] = 1'b1;
         end
      end else if (!m_aw_done[k]) begin
         if ((m_sel[k] ? s01_awvalid[k] : s00_awvalid[k]) && m_awready[k]) begin
            m_blen[k]    = m_sel[k] ? int'(s01_awlen[k]) : int'(s00_awlen[k]);
            m_beats[k]   = 0;
            m_aw_done[k] = 1'b1;
         end
      end else if (!m_w_done[k]) begin
         if (wvalid[k] && wready[k]) begin
            // m_beats counts beats already accepted, so it is this beat's index.
            if (wlast[k]) begin
               if (m_beats[k] != m_blen[k]) m_err[k] = 1'b1;
               m_w_done[k] = 1'b1;
            end else if (m_beats[k] == m_blen[k]) begin
               m_err[k] = 1'b1;
            end
            m_beats[k] = (m_beats[k] >= 255) ? 255 : m_beats[k] + 1;
         end
      end else if (bvalid[k] && bready[k]) begin
         m_prev[k]    = m_sel[k];
         m_active[k]  = 1'b0;
         m_aw_done[k] = 1'b0;
         m_w_done[k]  = 1'b0;
      end
   endtask

   task automatic check_outputs(input int k);
      bit in_addr, in_data, in_resp;
      in_addr = m_active[k] && !m_aw_done[k];
      in_data = m_aw_done[k] && !m_w_done[k];
      in_resp = m_w_done[k];
      chk($sformatf("sel[%0d]", k),       32'(sel_slave[k]),   32'(m_sel[k]));
      chk($sformatf("aw_en[%0d]", k),     32'(aw_en[k]),       32'(in_addr));
      chk($sformatf("w_en[%0d]", k),      32'(w_en[k]),        32'(in_data));
      chk($sformatf("b_en[%0d]", k),      32'(b_en[k]),        32'(in_resp));
      chk($sformatf("awready0[%0d]", k),  32'(s00_awready[k]),
          32'(in_addr && !m_sel[k] && m_awready[k]));
      chk($sformatf("awready1[%0d]", k),  32'(s01_awready[k]),
          32'(in_addr && m_sel[k] && m_awready[k]));
      chk($sformatf("wlast_err[%0d]", k), 32'(wlast_err[k]),   32'(m_err[k]));
   endtask

   task automatic drive_random(input int cyc);
      areset = (cyc < 3) || ($urandom_range(0, 299) == 0);
      for (int k = 0; k < 2; k++) begin
         s00_awvalid[k] = ($urandom_range(0, 9) < 5);
         s01_awvalid[k] = ($urandom_range(0, 9) < 5);
         s00_awlen[k]   = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 15))
                                                      : 8'($urandom_range(0, 3));
         s01_awlen[k]   = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 15))
                                                      : 8'($urandom_range(0, 3));
         m_awready[k]   = ($urandom_range(0, 9) < 5);
         wvalid[k]      = ($urandom_range(0, 9) < 7);
         wready[k]      = ($urandom_range(0, 9) < 7);
         wlast[k]       = ($urandom_range(0, 9) < 8) ? (m_beats[k] == m_blen[k])
                                                     : 1'($urandom_range(0, 1));
         bvalid[k]      = ($urandom_range(0, 9) < 5);
         bready[k]      = ($urandom_range(0, 9) < 7);
      end
   endtask

   initial begin
      areset      = 1'b1;
      s00_awvalid = 2'b00;
      s01_awvalid = 2'b00;
      m_awready   = 2'b00;
      wvalid      = 2'b00;
      wlast       = 2'b00;
      wready      = 2'b00;
      bvalid      = 2'b00;
      bready      = 2'b00;
      for (int k = 0; k < 2; k++) begin
         s00_awlen[k] = 8'd0;
         s01_awlen[k] = 8'd0;
         model_reset(k);
      end
      for (int c = 0; c < NCYC; c++) begin
         @(posedge clk);
         model_step(0);
         model_step(1);
         #1;
         drive_random(c);
         @(negedge clk);
         check_outputs(0);
         check_outputs(1);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
